// File: rtl/int_to_fp.sv
// int_to_fp: 8-bit sign-magnitude integer to 13-bit {sign, exp[3:0], frac[7:0]} float, iterative normalization.
// Define INT_TO_FP_FAST_NORM_EN to normalize up to two bits per clock (same results, shorter latency).
module int_to_fp (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  i_int,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [12:0] o_fp,
    output logic        o_zero,
    output logic        out_valid,
    input  logic        out_ready
);
    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [3:0]  exp_q, exp_d;
    logic [7:0]  frac_q, frac_d;
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        frac_d  = frac_q;
        case (state_q)
            IDLE: if (in_valid) begin
                sign_d  = i_int[7];
                frac_d  = {i_int[6:0], 1'b0};
                exp_d   = 4'd7;
                state_d = NORM;
            end
            NORM: if (frac_q == 8'd0) begin
                // negative zero is canonicalized to +0
                exp_d   = 4'd0;
                sign_d  = 1'b0;
                state_d = DONE;
            end else if (frac_q[7]) begin
                state_d = DONE;
`ifdef INT_TO_FP_FAST_NORM_EN
            end else if (!frac_q[6]) begin
                frac_d  = {frac_q[5:0], 2'b00};
                exp_d   = exp_q - 4'd2;
`endif
            end else begin
                frac_d  = {frac_q[6:0], 1'b0};
                exp_d   = exp_q - 4'd1;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            exp_q   <= 4'd0;
            frac_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            frac_q  <= frac_d;
        end
    end
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign o_fp      = {sign_q, exp_q, frac_q};
    assign o_zero    = out_valid && (frac_q == 8'd0);
endmodule

// File: tb/tb_int_to_fp.sv
// tb_int_to_fp: directed and exhaustive checks of int_to_fp against a behavioural float model.
module tb_int_to_fp;
    logic        clk, rst_n, in_valid, in_ready, o_zero, out_valid, out_ready;
    logic [7:0]  i_int;
    logic [12:0] o_fp;
    int          checks = 0;
    int          failures = 0;
    logic [7:0]  sb[$];
    logic [7:0]  cmp_v;

`ifdef INT_TO_FP_FAST_NORM_EN
    localparam int L05 = 3, L81 = 4;
`else
    localparam int L05 = 5, L81 = 7;
`endif

    int_to_fp dut (
        .clk(clk), .rst_n(rst_n), .i_int(i_int), .in_valid(in_valid), .in_ready(in_ready),
        .o_fp(o_fp), .o_zero(o_zero), .out_valid(out_valid), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end
    endtask

    // value = mag exactly; frac holds mag shifted so its top set bit lands in frac[7]
    function automatic logic [12:0] model_fp(input logic [7:0] v);
        int m = int'(v[6:0]);
        int p = 0;
        if (m == 0) return 13'h0000;
        while ((m >> p) > 1) p++;
        return {v[7], 4'(p + 1), 8'(m << (7 - p))};
    endfunction

    function automatic int model_lat(input logic [7:0] v);
        int m = int'(v[6:0]);
        int k = 7;
        if (m == 0) return 1;
        while (m > 0) begin
            m = m >> 1;
            k--;
        end
`ifdef INT_TO_FP_FAST_NORM_EN
        return (k + 1) / 2 + 1;
`else
        return k + 1;
`endif
    endfunction

    function automatic logic prop_ok(input logic [7:0] v, input logic [12:0] fp);
        int m = int'(v[6:0]);
        int e = int'(fp[11:8]);
        if (m == 0) return fp == 13'h0000;
        return fp[7] && (fp[12] == v[7]) && (m == (int'(fp[7:0]) >> (8 - e)));
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 32'(out_valid), 32'd0);
            end else begin
                cmp_v = sb[0];
                check("model_fp", 32'(o_fp), 32'(model_fp(cmp_v)));
                check("model_zero", 32'(o_zero), 32'(cmp_v[6:0] == 7'd0));
                check("property", 32'(prop_ok(cmp_v, o_fp)), 32'd1);
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic convert(input logic [7:0] v, input logic [12:0] efp, input logic ez,
                           input int elat, input int hold);
        int n;
        logic [12:0] held;
        @(negedge clk);
        i_int = v;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        sb.push_back(v);
        #1;
        n = 0;
        while (!out_valid && n < 20) begin
            in_valid = 1'b1;
            i_int = 8'h33;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        check("latency", 32'(n), 32'(elat));
        check("fp_lit", 32'(o_fp), 32'(efp));
        check("zero_lit", 32'(o_zero), 32'(ez));
        held = o_fp;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            i_int = 8'h7F;
            @(posedge clk);
            #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_fp", 32'(o_fp), 32'(held));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("handoff_valid", 32'(out_valid), 32'd0);
        check("handoff_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        i_int = 8'h00;
        check("pin_05", 32'(model_fp(8'h05)), 32'h03A0);
        check("pin_81", 32'(model_fp(8'h81)), 32'h1180);
        check("pin_7F", 32'(model_fp(8'h7F)), 32'h07FE);
        check("pin_lat01", 32'(model_lat(8'h01)), 32'(L81));
        check("pin_lat05", 32'(model_lat(8'h05)), 32'(L05));
        #13;
        check("rst_fp", 32'(o_fp), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_zero", 32'(o_zero), 32'd0);
        #10 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        convert(8'h05, 13'h03A0, 1'b0, L05, 0);
        convert(8'h81, 13'h1180, 1'b0, L81, 0);
        convert(8'h7F, 13'h07FE, 1'b0, 1, 0);
        convert(8'h80, 13'h0000, 1'b1, 1, 0);
        convert(8'h05, 13'h03A0, 1'b0, L05, 0);

        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("idle_rst_fp", 32'(o_fp), 32'd0);
        check("idle_rst_valid", 32'(out_valid), 32'd0);
        check("idle_rst_zero", 32'(o_zero), 32'd0);
        #2 rst_n = 1'b1;

        convert(8'h00, 13'h0000, 1'b1, 1, 0);
        convert(8'h05, 13'h03A0, 1'b0, L05, 5);

        @(negedge clk);
        i_int = 8'h01;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        check("norm_rst_fp", 32'(o_fp), 32'd0);
        check("norm_rst_valid", 32'(out_valid), 32'd0);
        check("norm_rst_zero", 32'(o_zero), 32'd0);
        #3 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("norm_rst_stale", 32'(out_valid), 32'd0);
        check("norm_rst_in_ready", 32'(in_ready), 32'd1);

        for (int v = 0; v < 256; v++)
            convert(8'(v), model_fp(8'(v)), 8'(v) ==? 8'b?000_0000, model_lat(8'(v)), 0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/int_to_fp.md
Name: int_to_fp

Overview:
- Sequential converter from 8-bit sign-magnitude integer to the team's 13-bit floating-point word {sign, exp[3:0], frac[7:0]}.
- FP value = frac/256 * 2^exp; frac normalized so frac[7]=1; zero encoded as frac=0, exp=0.
- Normalizes iteratively, one left shift per clock, behind valid/ready handshakes on both sides.
- Sits on the integer-to-float path, feeding FP datapath blocks.

Parameters:
- None. Widths are fixed by the 13-bit FP format and the 8-bit integer format.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
i_int  input  8  [7]=sign, [6:0]=magnitude
in_valid  input  1  i_int valid
in_ready  output  1  block can accept; high only in IDLE
o_fp  output  13  [12]=sign, [11:8]=exp, [7:0]=frac
o_zero  output  1  result is zero; valid with out_valid
out_valid  output  1  o_fp/o_zero valid
out_ready  input  1  consumer accepts result

Behaviour:
- Reset (async, rst_n=0): state=IDLE; o_fp=0, o_zero=0, out_valid=0; in_ready=1 once state is IDLE.
- States: IDLE, NORM, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready (accept edge):
  - latch sign=i_int[7], frac={i_int[6:0],1'b0}, exp=7;
  - go to NORM.
- NORM: each edge:
  - if frac==0: exp=0, sign=0 (negative zero canonicalized to +0), go to DONE;
  - else if frac[7]=1: go to DONE;
  - else: frac<=frac<<1, exp<=exp-1, stay in NORM.
- DONE: out_valid=1, o_fp={sign,exp,frac}, o_zero=(frac==0).
  - Outputs hold stable while out_ready=0.
  - On out_valid&&out_ready, go to IDLE and drop out_valid.
  - No same-cycle accept of a new input in DONE; in_ready=0.
- Latency:
  - k = leading zeros of {mag,0} before its first 1; k=0..6; k=0 for zero.
  - out_valid rises k+1 edges after the accept edge. Maximum is 7 (mag=1).
- Throughput: at most one conversion per k+3 cycles.
- Arithmetic:
  - exp is 4 bits and never below 1 for nonzero input. The minimum, 1, occurs at mag=1.
  - Result satisfies mag == frac >> (8-exp); no overflow or underflow is possible.
- in_valid outside IDLE is ignored; i_int need not be held after the accept edge.
- Reset mid-operation (NORM or DONE): abort immediately; pending result lost; outputs return to reset values.
- Simultaneous out_ready and in_valid in DONE: result handed off; new input not accepted until the next cycle (IDLE).

Optional Feature:
- Macro: INT_TO_FP_FAST_NORM_EN
- Defined: NORM shifts by 2 when frac[7:6]==00 (exp-=2), by 1 when frac[7:6]==01 (exp-=1). Latency becomes ceil(k/2)+1 edges; maximum 4.
- Undefined: one-bit-per-cycle normalization as above.
- Results are bit-identical in both builds; only latency differs.

Test Plan:
- Reset: assert rst_n=0 mid-idle -> o_fp=13'h0000, out_valid=0, o_zero=0; after release, in_ready=1.
- i_int=8'h05 -> o_fp=13'h03A0 (exp=3, frac=A0), o_zero=0; out_valid 5 edges after accept (3 with FAST_NORM).
- i_int=8'h81 -> o_fp=13'h1180 (sign=1, exp=1, frac=80); latency 7 edges (4 with FAST_NORM). i_int=8'h7F -> o_fp=13'h07FE; latency 1 edge.
- i_int=8'h80 and 8'h00 -> o_fp=13'h0000, o_zero=1, latency 1 edge.
- Backpressure: result ready with out_ready=0 for 5 cycles -> o_fp stable, out_valid=1, in_ready=0; in_valid pulses ignored. Then out_ready=1 -> IDLE next cycle.
- rst_n pulse during NORM for i_int=8'h01 -> outputs cleared, no stale out_valid. Then exhaustive sweep of all 256 inputs -> every result satisfies mag == frac>>(8-exp), frac[7]=1 for nonzero, sign preserved for nonzero.
